// File: rtl/seq_calculator.sv
// Multi-cycle calculator: add/sub finish in one cycle; mul, divide, remainder and sqrt
// each take W cycles (one shift-add, restoring-subtract or root bit per cycle).
module seq_calculator #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] result,
  output logic           busy,
  output logic           done,
  output logic           neg,
  output logic           err
);

  localparam int CW = $clog2(W + 1);
  localparam int RW = W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_QUO  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_REM  = 3'd4;
  localparam logic [2:0] OP_SQRT = 3'd5;

  logic [1:0]     state_r;
  logic [CW-1:0]  cnt_r;
  logic [2:0]     op_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [2*W-1:0] acc_r;
  logic [2*W-1:0] sh_r;
  logic [W-1:0]   q_r;
  logic [W:0]     rem_r;
  logic [2*W-1:0] result_r;
  logic           busy_r;
  logic           done_r;
  logic           neg_r;
  logic           err_r;

  logic [2*W-1:0] acc_nx_s;
  logic [2*W-1:0] sh_nx_s;
  logic [W-1:0]   q_nx_s;
  logic [W:0]     rem_nx_s;
  logic [W:0]     div_trial_s;
  logic [W+2:0]   sq_trial_s;
  logic [W+2:0]   sq_test_s;
  logic [W:0]     add_s;
  logic [W:0]     sub_s;
  logic [CW-1:0]  cnt_load_s;
  logic [2*W-1:0] res_fin_s;
  logic           neg_fin_s;
  logic           err_fin_s;

  // Illegal opcode (11x) or a divide/remainder with a zero divisor.
  function automatic logic op_err(input logic [2:0] o, input logic [W-1:0] d);
    logic illegal;
    logic div0;
    illegal = o[2] & o[1];
    div0    = ((o == OP_QUO) || (o == OP_REM)) && (d == {W{1'b0}});
    return illegal | div0;
  endfunction

  assign div_trial_s = {rem_r[W-1:0], q_r[W-1]};
  assign sq_trial_s  = {rem_r, sh_r[2*W-1:2*W-2]};
  assign sq_test_s   = {1'b0, q_r, 2'b01};
  assign add_s       = {1'b0, a_r} + {1'b0, b_r};
  assign sub_s       = {1'b0, a_r} - {1'b0, b_r};
  assign cnt_load_s  = (op_err(op, b) || (op == OP_ADD) || (op == OP_SUB)) ? CW'(1) : CW'(W);

  // One iteration of the selected multi-cycle algorithm.
  always_comb begin
    acc_nx_s = acc_r;
    sh_nx_s  = sh_r;
    q_nx_s   = q_r;
    rem_nx_s = rem_r;
    case (op_r)
      OP_MUL: begin
        if (q_r[0]) begin
          acc_nx_s = acc_r + sh_r;
        end else begin
          acc_nx_s = acc_r;
        end
        sh_nx_s = {sh_r[2*W-2:0], 1'b0};
        q_nx_s  = {1'b0, q_r[W-1:1]};
      end
      OP_QUO, OP_REM: begin
        if (div_trial_s >= {1'b0, b_r}) begin
          rem_nx_s = div_trial_s - {1'b0, b_r};
          q_nx_s   = {q_r[W-2:0], 1'b1};
        end else begin
          rem_nx_s = div_trial_s;
          q_nx_s   = {q_r[W-2:0], 1'b0};
        end
      end
      OP_SQRT: begin
        // rem never exceeds 2*root, so W+1 bits hold it between steps
        if (sq_trial_s >= sq_test_s) begin
          rem_nx_s = RW'(sq_trial_s - sq_test_s);
          q_nx_s   = {q_r[W-2:0], 1'b1};
        end else begin
          rem_nx_s = sq_trial_s[W:0];
          q_nx_s   = {q_r[W-2:0], 1'b0};
        end
        sh_nx_s = {sh_r[2*W-3:0], 2'b00};
      end
      default: begin
        acc_nx_s = acc_r;
      end
    endcase
  end

  // Completion values, using the last iteration's outputs for the multi-cycle ops.
  always_comb begin
    res_fin_s = {(2*W){1'b0}};
    neg_fin_s = 1'b0;
    err_fin_s = 1'b0;
    if (op_err(op_r, b_r)) begin
      res_fin_s = {(2*W){1'b1}};
      err_fin_s = 1'b1;
    end else begin
      case (op_r)
        OP_ADD:  res_fin_s = {{(W-1){1'b0}}, add_s};
        OP_SUB: begin
          res_fin_s = {{(W-1){sub_s[W]}}, sub_s};
          neg_fin_s = sub_s[W];
        end
        OP_MUL:  res_fin_s = acc_nx_s;
        OP_QUO:  res_fin_s = {{W{1'b0}}, q_nx_s};
        OP_REM:  res_fin_s = {{W{1'b0}}, rem_nx_s[W-1:0]};
        OP_SQRT: res_fin_s = {{W{1'b0}}, q_nx_s};
        default: begin
          res_fin_s = {(2*W){1'b1}};
          err_fin_s = 1'b1;
        end
      endcase
    end
  end

  // Control FSM, operand capture, iteration state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CW{1'b0}};
      op_r     <= 3'd0;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      sh_r     <= {(2*W){1'b0}};
      q_r      <= {W{1'b0}};
      rem_r    <= {(W+1){1'b0}};
      result_r <= {(2*W){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      neg_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_FIN: begin
          if (start) begin
            state_r <= S_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            cnt_r   <= cnt_load_s;
            op_r    <= op;
            a_r     <= a;
            b_r     <= b;
            acc_r   <= {(2*W){1'b0}};
            sh_r    <= (op == OP_MUL) ? {{W{1'b0}}, a} : {a, b};
            q_r     <= (op == OP_MUL) ? b : ((op == OP_SQRT) ? {W{1'b0}} : a);
            rem_r   <= {(W+1){1'b0}};
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        S_RUN: begin
          cnt_r <= cnt_r - CW'(1);
          acc_r <= acc_nx_s;
          sh_r  <= sh_nx_s;
          q_r   <= q_nx_s;
          rem_r <= rem_nx_s;
          if (cnt_r == CW'(1)) begin
            state_r  <= S_FIN;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= res_fin_s;
            neg_r    <= neg_fin_s;
            err_r    <= err_fin_s;
          end else begin
            state_r <= S_RUN;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign neg    = neg_r;
  assign err    = err_r;

endmodule

// File: tb/tb_seq_calculator.sv
// Directed bench for seq_calculator (W=4): expected results are queued when an
// operation is issued and compared when its done pulse appears.
module tb_seq_calculator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op_in;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [7:0] result;
  logic       busy;
  logic       done;
  logic       neg;
  logic       err;

  typedef struct {
    logic [7:0] res;
    logic       neg;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  seq_calculator #(.W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op_in),
    .a      (a_in),
    .b      (b_in),
    .result (result),
    .busy   (busy),
    .done   (done),
    .neg    (neg),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called just after a negedge; returns just after the negedge where done is seen.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] x,
                        input logic [3:0] y, input logic [7:0] exp_res, input logic exp_neg,
                        input logic exp_err, input int n, input bit poke);
    exp_t e;
    int   lat;
    int   busy_n;
    int   dc0;
    bit   seen;
    e.res = exp_res;
    e.neg = exp_neg;
    e.err = exp_err;
    sb.push_back(e);
    dc0   = done_cnt;
    op_in = o;
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat    = -1;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < n + 4 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      if (poke && i == 1) begin
        start = 1'b1;
        op_in = 3'd0;
        a_in  = 4'd1;
        b_in  = 4'd1;
      end
      if (poke && i == 2) start = 1'b0;
    end
    #1;
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, lat, n);
    check({tag, "_busy"}, busy_n, n);
    check({tag, "_pulses"}, done_cnt - dc0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_res"}, 32'(result), 32'(e.res));
      check({tag, "_neg"}, 32'(neg), 32'(e.neg));
      check({tag, "_err"}, 32'(err), 32'(e.err));
    end
  endtask

  // One cycle back in IDLE: done must have dropped after its single cycle.
  task automatic idle1(input string tag);
    @(negedge clk);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dc0;
    rst   = 1'b1;
    start = 1'b0;
    op_in = 3'd0;
    a_in  = 4'd0;
    b_in  = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add", 3'd0, 4'd9, 4'd5, 8'd14, 1'b0, 1'b0, 1, 1'b0);
    idle1("add");
    run_op("sub", 3'd1, 4'd3, 4'd9, 8'hFA, 1'b1, 1'b0, 1, 1'b0);
    idle1("sub");
    run_op("add_max", 3'd0, 4'd15, 4'd15, 8'd30, 1'b0, 1'b0, 1, 1'b0);
    idle1("add_max");
    run_op("mul", 3'd3, 4'd15, 4'd15, 8'd225, 1'b0, 1'b0, 4, 1'b1);
    idle1("mul");
    run_op("quo", 3'd2, 4'd13, 4'd4, 8'd3, 1'b0, 1'b0, 4, 1'b0);
    idle1("quo");
    run_op("rem", 3'd4, 4'd13, 4'd4, 8'd1, 1'b0, 1'b0, 4, 1'b0);
    idle1("rem");
    run_op("div0", 3'd2, 4'd13, 4'd0, 8'hFF, 1'b0, 1'b1, 1, 1'b0);
    idle1("div0");
    run_op("quo_clr", 3'd2, 4'd13, 4'd4, 8'd3, 1'b0, 1'b0, 4, 1'b0);
    idle1("quo_clr");
    run_op("illegal", 3'd6, 4'd1, 4'd2, 8'hFF, 1'b0, 1'b1, 1, 1'b0);
    idle1("illegal");

    // Reset during the second RUN cycle of a multiply: aborted, no done pulse.
    dc0   = done_cnt;
    op_in = 3'd3;
    a_in  = 4'd15;
    b_in  = 4'd15;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("abort_busy_run", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_result", 32'(result), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_neg", 32'(neg), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - dc0, 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);

    run_op("sqrt200", 3'd5, 4'd12, 4'd8, 8'd14, 1'b0, 1'b0, 4, 1'b0);
    idle1("sqrt200");
    run_op("sqrt255", 3'd5, 4'd15, 4'd15, 8'd15, 1'b0, 1'b0, 4, 1'b0);
    idle1("sqrt255");
    run_op("sqrt0", 3'd5, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 4, 1'b0);
    idle1("sqrt0");

    // Back-to-back: each new start is issued while the previous op sits in FIN.
    run_op("b2b_mul", 3'd3, 4'd7, 4'd9, 8'd63, 1'b0, 1'b0, 4, 1'b0);
    run_op("b2b_sub", 3'd1, 4'd9, 4'd3, 8'd6, 1'b0, 1'b0, 1, 1'b0);
    run_op("b2b_sub_neg", 3'd1, 4'd0, 4'd15, 8'hF1, 1'b1, 1'b0, 1, 1'b0);
    idle1("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_calculator.md
SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the operand width; legal values are 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op, input, 3 bits: 000 add, 001 sub, 010 quotient, 011 mul, 100 remainder, 101 sqrt, 110/111 illegal.
REQ-006 The block SHALL have port a, input, W bits: first operand (dividend, multiplicand, minuend; sqrt high half).
REQ-007 The block SHALL have port b, input, W bits: second operand (divisor, multiplier, subtrahend; sqrt low half).
REQ-008 The block SHALL have port result, output, 2W bits: registered result.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port neg, output, 1 bit: the sub result is negative.
REQ-012 The block SHALL have port err, output, 1 bit: divide by zero or illegal op.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FIN; busy=1 only in RUN; done=1 only in FIN.
REQ-014 start SHALL be accepted only in IDLE or FIN; on an accepted start at edge k, a, b and op are captured, the FSM enters RUN, and the iteration counter is loaded.
REQ-015 start SHALL be ignored in RUN; captured operands SHALL NOT change in RUN.
REQ-016 RUN SHALL last N cycles: N=1 for add, sub and error cases; N=W for mul, quotient and remainder (one shift-add or restoring-subtract step per cycle); N=W for sqrt (one result bit per cycle, MSB first).
REQ-017 At edge k+N, result, neg and err SHALL be written together, and the FSM SHALL enter FIN; done SHALL be high for exactly one cycle.
REQ-018 FIN SHALL go to IDLE on the next edge unless start is high, in which case a new operation is accepted (back-to-back, no idle cycle).
REQ-019 result, neg and err SHALL hold their values from FIN until the next completion; they SHALL NOT change during RUN.
REQ-020 add: result = zero-extended a+b, with the carry in bit W; neg=0.
REQ-021 sub: result = (a-b) mod 2^(2W) in two's complement, sign-extended; neg=1 if and only if a<b.
REQ-022 mul: result = a*b, unsigned, 2W bits; neg=0.
REQ-023 quotient / remainder: result = zero-extended floor(a/b) or a mod b.
REQ-024 sqrt: result = zero-extended floor(sqrt({a,b})), which fits in W bits.
REQ-025 On divide by zero (op 010 or 100 with b=0) or an illegal op, the block SHALL use N=1, set result to all ones, set err=1 and set neg=0; err SHALL clear at the next non-error completion.
REQ-026 All arithmetic SHALL be unsigned except sub; no internal overflow SHALL be possible for any legal W.

Reset
REQ-027 When rst=1 at an edge, the FSM SHALL go to IDLE and result, busy, done, neg, err and the counter SHALL be cleared to 0; this SHALL take priority over start and over any RUN or FIN activity.
REQ-028 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst is released SHALL operate normally.

Verification (W=4)
REQ-029 The bench SHALL check: op=000, a=9, b=5, start at edge k -> done at edge k+1, result=14, neg=0, err=0.
REQ-030 The bench SHALL check: op=001, a=3, b=9 -> result=8'hFA, neg=1; then op=000, a=15, b=15 -> result=30, neg=0.
REQ-031 The bench SHALL check: op=011, a=15, b=15 -> busy high for 4 cycles, done at k+4, result=225; a start pulsed mid-RUN SHALL be ignored.
REQ-032 The bench SHALL check: op=010 then op=100 with a=13, b=4 -> results 3 and 1; op=010 with b=0 -> result=8'hFF, err=1 after 1 RUN cycle.
REQ-033 The bench SHALL check: op=101, a=12, b=8 (radicand 200) -> result=14 at k+4; radicand 255 -> 15; radicand 0 -> 0.
REQ-034 The bench SHALL check: rst asserted in the 2nd RUN cycle of a mul -> no done pulse, all outputs 0 the next cycle; then a back-to-back start in FIN -> two consecutive correct results with one done each.
